// File: rtl/alu_pkg.sv
// ALU issue package: control codes, RV32I opcodes and funct fields,
// plus the decoded-instruction bundle shared by decoder and ID/EX stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_XOR   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_AND   = 4'h4,
        ALU_SLL   = 4'h5,
        ALU_SRL   = 4'h6,
        ALU_BEQ   = 4'h7,
        ALU_BNE   = 4'h8,
        ALU_SLT   = 4'h9,
        ALU_SRA   = 4'hA,
        ALU_AUIPC = 4'hB,
        ALU_BLT   = 4'hC,
        ALU_BGE   = 4'hD
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [0:0] {
        IN1_ZERO,
        IN1_RS1
    } in1_sel_e;

    typedef enum logic [1:0] {
        IN2_ZERO,
        IN2_RS2,
        IN2_RS2_SH,
        IN2_IMM
    } in2_sel_e;

    typedef struct packed {
        alu_ctrl_e   ctrl;
        in1_sel_e    in1_sel;
        in2_sel_e    in2_sel;
        logic [31:0] imm;
        logic        imm_sext;
        logic        imm_out_en;
        logic        rs2_fwd_en;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        illegal;
    } dec_t;

    // Shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic alu_ctrl_e arith_ctrl(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_ctrl_e c;
        c = ALU_ADD;
        case (f3)
            F3_ADD:  c = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  c = ALU_SLL;
            F3_SLT:  c = ALU_SLT;
            F3_SLTU: c = ALU_SLT;
            F3_XOR:  c = ALU_XOR;
            F3_SR:   c = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   c = ALU_OR;
            F3_AND:  c = ALU_AND;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode into ALU control, operand selects,
// immediate and pipeline control flags.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic        shift;
    logic        ok;
    dec_t        d;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign shift = (f3 == F3_SLL) || (f3 == F3_SR);

    // Per-opcode decode; any unsupported encoding collapses to an illegal no-op.
    always_comb begin
        d         = '0;
        d.ctrl    = ALU_ADD;
        d.in1_sel = IN1_ZERO;
        d.in2_sel = IN2_ZERO;
        ok        = 1'b0;
        unique case (opc)
            OPC_OP: begin
                ok = (f7 == F7_BASE) ||
                     ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                d.ctrl      = arith_ctrl(f3, f7 == F7_ALT);
                d.in1_sel   = IN1_RS1;
                d.in2_sel   = shift ? IN2_RS2_SH : IN2_RS2;
                d.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == F3_SLL)
                    ok = (f7 == F7_BASE);
                else if (f3 == F3_SR)
                    ok = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    ok = 1'b1;
                d.ctrl      = arith_ctrl(f3, (f3 == F3_SR) && (f7 == F7_ALT));
                d.in1_sel   = IN1_RS1;
                d.in2_sel   = IN2_IMM;
                d.imm       = shift ? {27'b0, instr[24:20]} : i_imm;
                d.imm_sext  = !shift;
                d.reg_write = 1'b1;
            end
            OPC_LUI: begin
                ok          = 1'b1;
                d.in2_sel   = IN2_IMM;
                d.imm       = {instr[31:12], 12'b0};
                d.imm_sext  = 1'b1;
                d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                ok          = 1'b1;
                d.ctrl      = ALU_AUIPC;
                d.in2_sel   = IN2_IMM;
                d.imm       = {12'b0, instr[31:12]};
                d.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                ok = 1'b1;
                case (f3)
                    F3_BEQ:  d.ctrl = ALU_BEQ;
                    F3_BNE:  d.ctrl = ALU_BNE;
                    F3_BLT:  d.ctrl = ALU_BLT;
                    F3_BLTU: d.ctrl = ALU_BLT;
                    F3_BGE:  d.ctrl = ALU_BGE;
                    F3_BGEU: d.ctrl = ALU_BGE;
                    default: ok = 1'b0;
                endcase
                d.in1_sel    = IN1_RS1;
                d.in2_sel    = IN2_RS2;
                d.imm        = b_imm;
                d.imm_sext   = 1'b1;
                d.imm_out_en = 1'b1;
                d.is_branch  = 1'b1;
            end
            OPC_LOAD: begin
                ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                     (f3 == F3_LBU) || (f3 == F3_LHU);
                d.in1_sel   = IN1_RS1;
                d.in2_sel   = IN2_IMM;
                d.imm       = i_imm;
                d.imm_sext  = 1'b1;
                d.mem_read  = 1'b1;
                d.reg_write = 1'b1;
            end
            OPC_STORE: begin
                ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
                d.in1_sel    = IN1_RS1;
                d.in2_sel    = IN2_IMM;
                d.imm        = s_imm;
                d.imm_sext   = 1'b1;
                d.imm_out_en = 1'b1;
                d.rs2_fwd_en = 1'b1;
                d.mem_write  = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d         = '0;
            d.ctrl    = ALU_ADD;
            d.in1_sel = IN1_ZERO;
            d.in2_sel = IN2_ZERO;
            d.illegal = 1'b1;
        end
    end

    assign dec = d;

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX stage feeding the execute ALU: registered decode with
// flush-over-stall priority and a count of legal issued instructions.
module id_ex_alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             stall,
    input  logic             flush,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [3:0]       alu_ctrl,
    output logic [XLEN-1:0]  alu_pc,
    output logic [XLEN-1:0]  imm_out,
    output logic [XLEN-1:0]  rs2_fwd,
    output logic [4:0]       rd_out,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             is_branch,
    output logic             illegal,
    output logic             valid_out,
    output logic [CNT_W-1:0] issue_count
);

    dec_t            dec;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] in1_d;
    logic [XLEN-1:0] in2_d;
    logic            issue;

    alu_ctrl_decode u_dec (
        .instr (instr),
        .dec   (dec)
    );

    assign imm_x = dec.imm_sext ? XLEN'($signed(dec.imm))
                                : XLEN'(dec.imm);

    assign issue = in_valid && !stall && !flush && !dec.illegal;

    // Operand muxes ahead of the ID/EX register.
    always_comb begin
        in1_d = '0;
        in2_d = '0;
        unique case (dec.in1_sel)
            IN1_RS1:  in1_d = rs1_data;
            default:  in1_d = '0;
        endcase
        unique case (dec.in2_sel)
            IN2_RS2:    in2_d = rs2_data;
            IN2_RS2_SH: in2_d = XLEN'(rs2_data[4:0]);
            IN2_IMM:    in2_d = imm_x;
            default:    in2_d = '0;
        endcase
    end

    // ID/EX register: reset/flush/idle slot load a bubble, stall holds.
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !in_valid)) begin
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_ctrl  <= '0;
            alu_pc    <= '0;
            imm_out   <= '0;
            rs2_fwd   <= '0;
            rd_out    <= '0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            is_branch <= 1'b0;
            illegal   <= 1'b0;
            valid_out <= 1'b0;
        end else if (!stall) begin
            alu_in1   <= in1_d;
            alu_in2   <= in2_d;
            alu_ctrl  <= dec.ctrl;
            alu_pc    <= pc_in;
            imm_out   <= dec.imm_out_en ? imm_x : '0;
            rs2_fwd   <= dec.rs2_fwd_en ? rs2_data : '0;
            rd_out    <= instr[11:7];
            reg_write <= dec.reg_write;
            mem_read  <= dec.mem_read;
            mem_write <= dec.mem_write;
            is_branch <= dec.is_branch;
            illegal   <= dec.illegal;
            valid_out <= 1'b1;
        end
    end

    // Legal-issue counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst)
            issue_count <= '0;
        else if (issue)
            issue_count <= issue_count + 1'b1;
    end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: directed and random stimulus
// against a spec-level reference model, plus a narrow-counter instance.
module tb_id_ex_alu_issue;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs2f;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
        logic        vld;
        logic        ck_in;
        logic        ck_imm;
        logic        ck_rs2;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush;
    logic [31:0] instr, pc_in, rs1_data, rs2_data;

    logic [31:0] alu_in1, alu_in2, alu_pc, imm_out, rs2_fwd, issue_count;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd_out;
    logic        reg_write, mem_read, mem_write, is_branch, illegal, valid_out;

    logic [31:0] w_in1, w_in2, w_pc, w_imm, w_rs2f;
    logic [3:0]  w_ctrl, w_cnt;
    logic [4:0]  w_rd;
    logic        w_rw, w_mr, w_mw, w_br, w_ill, w_vld;

    exp_t sb[$];
    exp_t m;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_ex_alu_issue u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .pc_in(pc_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .flush(flush),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_pc(alu_pc), .imm_out(imm_out), .rs2_fwd(rs2_fwd),
        .rd_out(rd_out), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .is_branch(is_branch), .illegal(illegal),
        .valid_out(valid_out), .issue_count(issue_count)
    );

    id_ex_alu_issue #(.CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .pc_in(pc_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .flush(flush),
        .alu_in1(w_in1), .alu_in2(w_in2), .alu_ctrl(w_ctrl),
        .alu_pc(w_pc), .imm_out(w_imm), .rs2_fwd(w_rs2f),
        .rd_out(w_rd), .reg_write(w_rw), .mem_read(w_mr),
        .mem_write(w_mw), .is_branch(w_br), .illegal(w_ill),
        .valid_out(w_vld), .issue_count(w_cnt)
    );

    function automatic exp_t bubble(input logic [31:0] cnt);
        exp_t e;
        e.in1 = 0; e.in2 = 0; e.pc = 0; e.imm = 0; e.rs2f = 0;
        e.ctrl = 0; e.rd = 0;
        e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 0; e.vld = 0;
        e.ck_in = 1; e.ck_imm = 1; e.ck_rs2 = 1;
        e.cnt = cnt;
        return e;
    endfunction

    // Reference decode straight from the instruction-set rules.
    function automatic exp_t ref_dec(input logic [31:0] ins,
                                     input logic [31:0] p,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        exp_t        e;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] i_imm, s_imm, b_imm;
        logic        ok;
        int          c;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        i_imm = 32'($signed(ins[31:20]));
        s_imm = 32'($signed({ins[31:25], ins[11:7]}));
        b_imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        e = bubble(0);
        e.vld = 1; e.rd = ins[11:7]; e.pc = p;
        ok = 1; c = 0;
        case (opc)
            7'h33: begin
                e.in1 = a; e.in2 = b; e.rw = 1;
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                case (f3)
                    0: c = (f7 == 7'h20) ? 1 : 0;
                    1: begin c = 5; e.in2 = b % 32; end
                    2, 3: c = 9;
                    4: c = 2;
                    5: begin c = (f7 == 7'h20) ? 10 : 6; e.in2 = b % 32; end
                    6: c = 3;
                    default: c = 4;
                endcase
            end
            7'h13: begin
                e.in1 = a; e.in2 = i_imm; e.rw = 1;
                case (f3)
                    0: c = 0;
                    1: begin c = 5; e.in2 = 32'(ins[24:20]); ok = (f7 == 0); end
                    2, 3: c = 9;
                    4: c = 2;
                    5: begin
                        e.in2 = 32'(ins[24:20]);
                        if (f7 == 0) c = 6;
                        else if (f7 == 7'h20) c = 10;
                        else ok = 0;
                    end
                    6: c = 3;
                    default: c = 4;
                endcase
            end
            7'h37: begin e.in2 = {ins[31:12], 12'h0}; e.rw = 1; end
            7'h17: begin c = 11; e.in2 = 32'(ins[31:12]); e.rw = 1; end
            7'h63: begin
                e.in1 = a; e.in2 = b; e.imm = b_imm; e.br = 1;
                case (f3)
                    0: c = 7;
                    1: c = 8;
                    4, 6: c = 12;
                    5, 7: c = 13;
                    default: ok = 0;
                endcase
            end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.in1 = a; e.in2 = i_imm; e.mr = 1; e.rw = 1;
            end
            7'h23: begin
                ok = (f3 <= 2);
                e.in1 = a; e.in2 = s_imm; e.imm = s_imm;
                e.rs2f = b; e.mw = 1;
            end
            default: ok = 0;
        endcase
        e.ctrl   = 4'(c);
        e.ck_in  = ok;
        e.ck_imm = ok && (opc == 7'h63 || opc == 7'h23);
        e.ck_rs2 = ok && (opc == 7'h23);
        if (!ok) begin
            e.ctrl = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 1;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic v, input logic s,
                        input logic f, input logic [31:0] ins,
                        input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b);
        exp_t d;
        rst = r; in_valid = v; stall = s; flush = f;
        instr = ins; pc_in = p; rs1_data = a; rs2_data = b;
        if (r)
            m = bubble(0);
        else if (f)
            m = bubble(m.cnt);
        else if (!s) begin
            if (!v)
                m = bubble(m.cnt);
            else begin
                d = ref_dec(ins, p, a, b);
                d.cnt = m.cnt + (d.ill ? 0 : 1);
                m = d;
            end
        end
        @(posedge clk);
        sb.push_back(m);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        w = $urandom;
        case ($urandom_range(0, 3))
            0, 1: f7 = 7'h00;
            2: f7 = 7'h20;
            default: f7 = w[31:25];
        endcase
        case ($urandom_range(0, 9))
            0, 1: return {f7, w[24:7], 7'h33};
            2, 3: return {f7, w[24:7], 7'h13};
            4: return {w[31:7], 7'h37};
            5: return {w[31:7], 7'h17};
            6: return {w[31:7], 7'h63};
            7: return {w[31:7], 7'h03};
            8: return {w[31:7], 7'h23};
            default: return w;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string t, input exp_t e,
                           input logic [31:0] cnt_exp,
                           input logic [31:0] in1, input logic [31:0] in2,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] r2f, input logic [3:0] ctl,
                           input logic [4:0] rd, input logic rw,
                           input logic mr, input logic mw, input logic br,
                           input logic ill, input logic vld,
                           input logic [31:0] cnt);
        chk({t, ".valid_out"}, 32'(vld), 32'(e.vld));
        chk({t, ".alu_ctrl"}, 32'(ctl), 32'(e.ctrl));
        chk({t, ".reg_write"}, 32'(rw), 32'(e.rw));
        chk({t, ".mem_read"}, 32'(mr), 32'(e.mr));
        chk({t, ".mem_write"}, 32'(mw), 32'(e.mw));
        chk({t, ".is_branch"}, 32'(br), 32'(e.br));
        chk({t, ".illegal"}, 32'(ill), 32'(e.ill));
        chk({t, ".rd_out"}, 32'(rd), 32'(e.rd));
        chk({t, ".alu_pc"}, pc, e.pc);
        chk({t, ".issue_count"}, cnt, cnt_exp);
        if (e.ck_in) begin
            chk({t, ".alu_in1"}, in1, e.in1);
            chk({t, ".alu_in2"}, in2, e.in2);
        end
        if (e.ck_imm)
            chk({t, ".imm_out"}, imm, e.imm);
        if (e.ck_rs2)
            chk({t, ".rs2_fwd"}, r2f, e.rs2f);
    endtask

    // Monitor: one registered result per edge, popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                chk_all("dut", e, e.cnt, alu_in1, alu_in2, alu_pc,
                        imm_out, rs2_fwd, alu_ctrl, rd_out, reg_write,
                        mem_read, mem_write, is_branch, illegal,
                        valid_out, issue_count);
                chk_all("wrap", e, {28'b0, e.cnt[3:0]}, w_in1, w_in2,
                        w_pc, w_imm, w_rs2f, w_ctrl, w_rd, w_rw, w_mr,
                        w_mw, w_br, w_ill, w_vld, 32'(w_cnt));
            end
        end
    end

    initial begin
        logic r, v, s, f;
        m = bubble(0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 32'h002081B3, 32'h10, 32'd5, 32'd7);
        step(0, 1, 0, 0, 32'h40335293, 32'h11, 32'h80000000, 32'h0);
        step(0, 1, 0, 0, 32'h12345097, 32'h40, 32'hDEAD, 32'hBEEF);
        step(0, 1, 0, 0, 32'h00209463, 32'h41, 32'd3, 32'd4);
        step(0, 1, 1, 0, 32'h002081B3, 32'h50, 32'd1, 32'd2);
        step(0, 1, 1, 0, 32'h002081B3, 32'h50, 32'd1, 32'd2);
        step(0, 1, 0, 0, 32'h002081B3, 32'h50, 32'd1, 32'd2);
        step(0, 1, 1, 1, 32'h00209463, 32'h51, 32'd9, 32'd9);
        step(0, 1, 0, 0, 32'h02208033, 32'h52, 32'd6, 32'd7);
        step(0, 1, 0, 0, 32'h0000007F, 32'h53, 32'd6, 32'd7);
        step(0, 1, 0, 0, 32'hFE20AE23, 32'h54, 32'h100, 32'h55);
        step(0, 0, 0, 0, 32'h002081B3, 32'h55, 32'd1, 32'd2);
        step(1, 1, 1, 0, 32'h002081B3, 32'h56, 32'd1, 32'd2);
        step(1, 1, 1, 1, 32'h002081B3, 32'h56, 32'd1, 32'd2);
        step(0, 1, 0, 0, 32'h123450B7, 32'h57, 32'd1, 32'd2);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 99) < 15);
            f = ($urandom_range(0, 99) < 8);
            step(r, v, s, f, rnd_instr(), $urandom, $urandom, $urandom);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
